// File: rtl/vis_framer.sv
// Visibility byte-stream framer: SOF, seq, payload, 16-bit length, optional XOR checksum.
// Optional checksum trailer enabled by defining VIS_FRAMER_CSUM_EN; registered outputs, 1-cycle byte latency.
module vis_framer #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  localparam int LBITS = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  output logic [7:0] seq_o,
  output logic       overflow_o
);

`ifdef VIS_FRAMER_CSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, LEN0, LEN1, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, LEN0, LEN1} state_t;
`endif

  state_t             r_state;
  state_t             w_nxt;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  logic [7:0]         r_m_tdata;
  logic [7:0]         r_seq;
  logic [LBITS-1:0]   r_cnt;
  logic               r_ovf;
`ifdef VIS_FRAMER_CSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_slot;
  logic               w_load;
  logic               w_last;
  logic               w_sof;
  logic               w_acc;
  logic [7:0]         w_dat;

  assign w_slot = !r_m_tvalid || m_tready;

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    w_sof  = 1'b0;
    w_acc  = 1'b0;
    w_dat  = 8'h00;
    case (r_state)
      // SOF goes out ahead of the first payload byte, which stays pending upstream
      IDLE: if (s_tvalid && w_slot) begin
        w_load = 1'b1;
        w_sof  = 1'b1;
        w_dat  = SOF_BYTE;
        w_nxt  = HDR;
      end
      HDR: if (w_slot) begin
        w_load = 1'b1;
        w_dat  = r_seq;
        w_nxt  = DATA;
      end
      DATA: if (s_tvalid && w_slot) begin
        w_load = 1'b1;
        w_acc  = 1'b1;
        w_dat  = s_tdata;
        if (s_tlast) w_nxt = LEN0;
      end
      LEN0: if (w_slot) begin
        w_load = 1'b1;
        w_dat  = r_cnt[7:0];
        w_nxt  = LEN1;
      end
      LEN1: if (w_slot) begin
        w_load = 1'b1;
        w_dat  = r_cnt[15:8];
`ifdef VIS_FRAMER_CSUM_EN
        w_nxt  = CSUM;
`else
        w_last = 1'b1;
        w_nxt  = IDLE;
`endif
      end
`ifdef VIS_FRAMER_CSUM_EN
      CSUM: if (w_slot) begin
        w_load = 1'b1;
        w_dat  = r_csum;
        w_last = 1'b1;
        w_nxt  = IDLE;
      end
`endif
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= 8'h00;
      r_seq      <= 8'h00;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
`ifdef VIS_FRAMER_CSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_state <= w_nxt;
      if (w_load) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_dat;
        r_m_tlast  <= w_last;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
      if (w_load && w_last) r_seq <= r_seq + 8'd1;
      // count sticks at all-ones; further payload bytes only flag overflow
      if (w_sof) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        if (r_cnt == {LBITS{1'b1}}) r_ovf <= 1'b1;
        else                        r_cnt <= r_cnt + 16'd1;
      end
`ifdef VIS_FRAMER_CSUM_EN
      if (w_sof)       r_csum <= SOF_BYTE;
      else if (w_load) r_csum <= r_csum ^ w_dat;
`endif
    end
  end

  assign s_tready   = reset_n && (r_state == DATA) && w_slot;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign m_tdata    = r_m_tdata;
  assign seq_o      = r_seq;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_vis_framer.sv
// Bench for vis_framer: packet-level reference model, table-driven frames, corner sequences.
module tb_vis_framer;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata, seq_o;
  logic       overflow_o;

  vis_framer dut (
    .clock(clock), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .seq_o(seq_o), .overflow_o(overflow_o)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] d; logic l; } ob_t;
  typedef struct { int len; int rmode; logic [7:0] lo; logic [7:0] hi; logic ovf; } vec_t;

  ob_t        expq[$];
  logic [7:0] cur_pkt[$];
  logic [7:0] last_pkt[$];
  logic [7:0] mseq;
  int         total = 0;
  int         bad = 0;
  int         rmode = 0;
  int         cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    cyc++;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = cyc[0];
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // output monitor: every valid byte must match the head of the expected stream
  always @(negedge clock) begin
    if (!reset_n) begin
      cur_pkt.delete();
    end else if (m_tvalid) begin
      if (expq.size() == 0) begin
        chk("unexpected_byte", {23'd0, m_tlast, m_tdata}, 32'hDEAD);
      end else begin
        chk("out_data", m_tdata, expq[0].d);
        chk("out_last", m_tlast, expq[0].l);
        if (m_tready) begin
          void'(expq.pop_front());
          cur_pkt.push_back(m_tdata);
          if (m_tlast) begin
            last_pkt = cur_pkt;
            cur_pkt.delete();
          end
        end
      end
    end
  end

  task automatic send_frame(input int len, input int dmode, input bit gap, input int abort);
    logic [7:0] pay[$];
    logic [7:0] cs;
    int n, t;
    bit hs;
    for (int i = 0; i < len; i++) pay.push_back(dmode == 0 ? 8'(i + 1) : 8'($urandom));
    n = (len > 65535) ? 65535 : len;
    cs = 8'hA5 ^ mseq;
    expq.push_back('{8'hA5, 1'b0});
    expq.push_back('{mseq, 1'b0});
    foreach (pay[i]) begin
      expq.push_back('{pay[i], 1'b0});
      cs = cs ^ pay[i];
    end
    expq.push_back('{n[7:0], 1'b0});
    cs = cs ^ n[7:0] ^ n[15:8];
`ifdef VIS_FRAMER_CSUM_EN
    expq.push_back('{n[15:8], 1'b0});
    expq.push_back('{cs, 1'b1});
`else
    expq.push_back('{n[15:8], 1'b1});
`endif
    mseq = mseq + 8'd1;
    for (int i = 0; i < len; i++) begin
      if (abort != 0 && i == abort) break;
      if (gap && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clock); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = pay[i];
      s_tlast  = (i == len - 1);
      t = 0;
      do begin
        @(negedge clock); hs = s_tready;
        @(posedge clock); #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        chk("input_handshake_timeout", 32'(t), 32'd0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin
      @(posedge clock); #1;
      t++;
    end
    if (expq.size() != 0) begin
      chk("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    expq.delete();
    mseq = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, 8'h00);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_seq_o", seq_o, 8'h00);
    chk("rst_overflow", overflow_o, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] exp31[$];
    m_tready = 1'b1;
    s_tdata  = 8'h00;
    mseq     = 8'h00;
    @(posedge clock); #1;
    do_reset();

    // directed 01..08 frame, full-rate then toggling ready
`ifdef VIS_FRAMER_CSUM_EN
    exp31 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00, 8'hA5};
`else
    exp31 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00};
`endif
    for (int r = 0; r < 2; r++) begin
      rmode = r;
      send_frame(8, 0, 1'b0, 0);
      wait_drain();
      chk("pkt8_size", 32'(last_pkt.size()), 32'(exp31.size()));
      foreach (exp31[i]) if (i < last_pkt.size()) chk("pkt8_byte", last_pkt[i], exp31[i]);
      chk("pkt8_seq_after", seq_o, 8'h01);
      do_reset();
    end

    // table of frame lengths around the length-byte boundaries
    vecs = '{'{1, 0, 8'h01, 8'h00, 1'b0}, '{2, 1, 8'h02, 8'h00, 1'b0},
             '{255, 2, 8'hFF, 8'h00, 1'b0}, '{256, 2, 8'h00, 8'h01, 1'b0},
             '{300, 1, 8'h2C, 8'h01, 1'b0}};
    foreach (vecs[k]) begin
      rmode = vecs[k].rmode;
      send_frame(vecs[k].len, 1, 1'b1, 0);
      wait_drain();
      if (last_pkt.size() == vecs[k].len + 4 + 0
`ifdef VIS_FRAMER_CSUM_EN
          + 1
`endif
         ) begin
        chk("vec_len_lo", last_pkt[vecs[k].len + 2], vecs[k].lo);
        chk("vec_len_hi", last_pkt[vecs[k].len + 3], vecs[k].hi);
      end else begin
        chk("vec_pkt_size", 32'(last_pkt.size()), 32'(vecs[k].len + 4));
      end
      chk("vec_overflow", overflow_o, vecs[k].ovf);
      chk("vec_seq", seq_o, mseq);
    end

    // randomized frames against the model
    rmode = 2;
    for (int k = 0; k < 20; k++) begin
      send_frame($urandom_range(1, 40), 1, 1'b1, 0);
      wait_drain();
      chk("rand_seq", seq_o, mseq);
    end

    // sequence wrap over 257 single-byte frames
    do_reset();
    rmode = 0;
    for (int k = 0; k < 256; k++) send_frame(1, 1, 1'b0, 0);
    wait_drain();
    chk("wrap_seq_o", seq_o, 8'h00);
    chk("wrap_last_seq_byte", last_pkt[1], 8'hFF);
    send_frame(1, 1, 1'b0, 0);
    wait_drain();
    chk("wrap_257_seq_byte", last_pkt[1], 8'h00);

    // reset mid-frame, then a clean 2-byte frame
    rmode = 0;
    send_frame(6, 0, 1'b0, 3);
    reset_n = 1'b0;
    expq.delete();
    mseq = 8'h00;
    @(posedge clock); #1;
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    @(posedge clock); #1;
    chk("midrst_m_tvalid2", m_tvalid, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    send_frame(2, 1, 1'b0, 0);
    wait_drain();
    chk("midrst_sof", last_pkt[0], 8'hA5);
    chk("midrst_seq", last_pkt[1], 8'h00);
    chk("midrst_len_lo", last_pkt[4], 8'h02);
    chk("midrst_len_hi", last_pkt[5], 8'h00);

    // payload count saturation
    send_frame(65540, 1, 1'b0, 0);
    wait_drain();
    chk("sat_len_lo", last_pkt[65542], 8'hFF);
    chk("sat_len_hi", last_pkt[65543], 8'hFF);
    chk("sat_overflow", overflow_o, 1'b1);
    send_frame(3, 1, 1'b0, 0);
    wait_drain();
    chk("sat_overflow_sticky", overflow_o, 1'b1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vis_framer.md
VIS_FRAMER -- requirements
Module: vis_framer

Interface
REQ-001 SHALL provide parameter SOF_BYTE, default 8'hA5, the start-of-frame marker byte.
REQ-002 SHALL provide parameter LBITS, fixed at 16, the payload byte-counter width (not overridable).
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_tvalid  input  1  upstream byte-stream (visibility bytes) valid.
REQ-006 SHALL have port s_tready  output  1  upstream ready.
REQ-007 SHALL have port s_tlast  input  1  last payload byte of a visibility frame.
REQ-008 SHALL have port s_tdata  input  8  payload byte.
REQ-009 SHALL have port m_tvalid  output  1  framed-stream valid, toward the USB/SPI host link.
REQ-010 SHALL have port m_tready  input  1  framed-stream ready.
REQ-011 SHALL have port m_tlast  output  1  final byte of a framed packet.
REQ-012 SHALL have port m_tdata  output  8  framed byte.
REQ-013 SHALL have port seq_o  output  8  sequence number of the next frame.
REQ-014 SHALL have port overflow_o  output  1  sticky payload-count saturation flag.

Function
REQ-015 SHALL emit each packet as: SOF_BYTE, seq, payload bytes, len[7:0], len[15:8], then csum only when checksum is enabled (REQ-030).
REQ-016 SHALL register all m_* outputs; "slot free" is defined as (!m_tvalid || m_tready).
REQ-017 SHALL hold m_tdata and m_tlast stable while m_tvalid && !m_tready.
REQ-018 SHALL implement FSM states IDLE, HDR, DATA, LEN0, LEN1, CSUM.
REQ-019 IDLE: on s_tvalid && slot free, SHALL load SOF_BYTE into the output register and go to HDR, without consuming the input byte.
REQ-020 HDR: on slot free, SHALL load seq_o into the output register and go to DATA.
REQ-021 DATA: s_tready SHALL equal slot free; on each accepted byte it SHALL load s_tdata into the output register, increment the count, update csum, and go to LEN0 if s_tlast is set.
REQ-022 s_tready SHALL be 0 in every state other than DATA.
REQ-023 Latency SHALL be one cycle from an accepted input byte to m_tvalid carrying that byte.
REQ-024 LEN0 and LEN1 SHALL each load one length byte when slot free.
REQ-025 The payload count SHALL reset to 0 at each SOF, count payload bytes only, and saturate at 16'hFFFF; saturation SHALL set overflow_o.
REQ-026 csum SHALL be the 8-bit XOR of every byte emitted earlier in the same packet (SOF, seq, payload, both length bytes).
REQ-027 The packet's final byte SHALL be loaded with m_tlast=1; in the same cycle seq_o SHALL increment, wrapping 8'hFF to 8'h00, and the FSM SHALL return to IDLE.
REQ-028 A new SOF SHALL be issued no earlier than the cycle after the previous final byte is accepted downstream.

Reset
REQ-029 When reset_n=0 at a clock edge, the block SHALL set FSM to IDLE, m_tvalid=0, m_tlast=0, m_tdata=8'h00, s_tready=0, seq_o=8'h00, overflow_o=0, count=0 and csum=0; a frame in progress is abandoned with no trailer.

Configuration
REQ-030 SHALL use macro VIS_FRAMER_CSUM_EN: when defined, the CSUM state emits csum as the final byte with m_tlast=1; when undefined, the CSUM state and checksum logic are absent and m_tlast=1 is set on len[15:8].

Verification
REQ-031 With CSUM_EN and m_tready=1, payload 01..08 with tlast on 08 -> output A5,00,01,02,03,04,05,06,07,08,08,00,A5; m_tlast only on the last byte; seq_o becomes 01.
REQ-032 Same stimulus, CSUM_EN undefined -> output A5,00,01..08,08,00; m_tlast on the final 00.
REQ-033 Same stimulus, m_tready toggling 1010... -> identical byte sequence, no loss or duplication, m_tdata stable during each stall.
REQ-034 256 back-to-back single-byte frames -> seq bytes 00..FF; the 257th frame carries seq 00.
REQ-035 Assert reset_n=0 after the 3rd payload byte of a frame, then send a new 2-byte frame -> m_tvalid=0 during reset; new packet starts A5,00 with len 02,00.
REQ-036 Single frame of 65540 bytes -> len bytes FF,FF; overflow_o=1 and it stays 1 until reset.
